prg_upload: RTL and testbench

//  Reads a VIC-20 memory range and streams it to the host as a .PRG image: 2-byte little-endian load address, then data bytes.

---
 rtl/prg_upload_pkg.sv | 30 +++
 rtl/prg_upload_if.sv | 22 ++
 rtl/prg_upload.sv | 234 +++++++++++++++++++++++
 tb/tb_prg_upload.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prg_upload_pkg.sv
// Shared types and defaults for the PRG upload streamer.
package prg_upload_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PTR,
        ST_CHK,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_RD,
        ST_OUT,
        ST_TRL,
        ST_FIN
    } state_t;

    localparam logic [15:0] DEF_TXTTAB_ADDR    = 16'h002B;
    localparam logic [15:0] DEF_VARTAB_ADDR    = 16'h002D;
    localparam int          DEF_TIMEOUT_CYCLES = 255;

    // Read-timeout counter width; supports TIMEOUT_CYCLES up to 255.
    localparam int TMO_W = 8;

    // Pointer fetch order: TXTTAB lo, TXTTAB hi, VARTAB lo, VARTAB hi.
    function automatic logic [15:0] ptr_addr(input logic [15:0] txt_base,
                                             input logic [15:0] var_base,
                                             input logic [1:0]  idx);
        return (idx[1] ? var_base : txt_base) + {15'd0, idx[0]};
    endfunction

endpackage

// File: rtl/prg_upload_if.sv
// Memory read port and upload byte stream shared by the streamer and its peers.
interface prg_upload_if;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_din;
    logic [7:0]  up_data;
    logic        up_valid;
    logic        up_ready;

    modport master (
        output mem_addr, mem_rd, up_data, up_valid,
        input  mem_ack, mem_din, up_ready
    );

    modport slave (
        input  mem_addr, mem_rd, up_data, up_valid,
        output mem_ack, mem_din, up_ready
    );

endinterface

// File: rtl/prg_upload.sv
// Streams a VIC-20 memory range to the host as a .PRG image (load address, then data).
// Optional XOR trailer byte when PRG_UPLOAD_CHECKSUM_EN is defined.
module prg_upload
    import prg_upload_pkg::*;
#(
    parameter logic [15:0] TXTTAB_ADDR    = DEF_TXTTAB_ADDR,
    parameter logic [15:0] VARTAB_ADDR    = DEF_VARTAB_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_auto_range,
    input  logic [15:0]        i_start_addr,
    input  logic [15:0]        i_end_addr,
    prg_upload_if.master       bus,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state,    w_state;
    logic [15:0]       r_cur_addr, w_cur_addr;
    logic [15:0]       r_end_addr, w_end_addr;
    logic [1:0]        r_ptr_idx,  w_ptr_idx;
    logic [TMO_W-1:0]  r_tmo_cnt,  w_tmo_cnt;
    logic [15:0]       r_mem_addr, w_mem_addr;
    logic              r_mem_rd,   w_mem_rd;
    logic [7:0]        r_up_data,  w_up_data;
    logic              r_up_valid, w_up_valid;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;
    logic              r_error,    w_error;
`ifdef PRG_UPLOAD_CHECKSUM_EN
    logic [7:0]        r_csum,     w_csum;
`endif

    logic w_rd_fire, w_tmo_hit, w_accept, w_issue_rd, w_end_stream;

    assign w_rd_fire = r_mem_rd & bus.mem_ack;
    assign w_tmo_hit = r_mem_rd & ~bus.mem_ack & (r_tmo_cnt == TMO_LAST);
    assign w_accept  = r_up_valid & bus.up_ready;

    // NOTE: every w_ signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state      = r_state;
        w_cur_addr   = r_cur_addr;
        w_end_addr   = r_end_addr;
        w_ptr_idx    = r_ptr_idx;
        w_tmo_cnt    = r_tmo_cnt;
        w_mem_addr   = r_mem_addr;
        w_mem_rd     = r_mem_rd;
        w_up_data    = r_up_data;
        w_up_valid   = r_up_valid;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_issue_rd   = 1'b0;
        w_end_stream = 1'b0;
`ifdef PRG_UPLOAD_CHECKSUM_EN
        w_csum       = r_csum;
`endif
        if (r_mem_rd && !bus.mem_ack)
            w_tmo_cnt = r_tmo_cnt + TMO_W'(1);

        if (i_abort) begin
            w_state    = ST_IDLE;
            w_mem_rd   = 1'b0;
            w_up_valid = 1'b0;
            w_busy     = 1'b0;
        end else if (w_tmo_hit) begin
            w_state  = ST_IDLE;
            w_mem_rd = 1'b0;
            w_busy   = 1'b0;
            w_error  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    w_state = ST_IDLE;
                    if (i_start) begin
                        w_busy     = 1'b1;
                        w_cur_addr = i_start_addr;
                        w_end_addr = i_end_addr;
`ifdef PRG_UPLOAD_CHECKSUM_EN
                        w_csum     = 8'h00;
`endif
                        if (i_auto_range) begin
                            w_state    = ST_PTR;
                            w_ptr_idx  = 2'd0;
                            w_mem_addr = TXTTAB_ADDR;
                            w_mem_rd   = 1'b1;
                            w_tmo_cnt  = '0;
                        end else begin
                            w_state = ST_CHK;
                        end
                    end
                end
                ST_PTR: begin
                    if (w_rd_fire) begin
                        w_mem_rd  = 1'b0;
                        w_ptr_idx = r_ptr_idx + 2'd1;
                        case (r_ptr_idx)
                            2'd0:    w_cur_addr[7:0]  = bus.mem_din;
                            2'd1:    w_cur_addr[15:8] = bus.mem_din;
                            2'd2:    w_end_addr[7:0]  = bus.mem_din;
                            default: w_end_addr[15:8] = bus.mem_din;
                        endcase
                        if (r_ptr_idx == 2'd3)
                            w_state = ST_CHK;
                    end else if (!r_mem_rd) begin
                        // One idle cycle between pointer reads keeps mem_rd edges distinct.
                        w_mem_addr = ptr_addr(TXTTAB_ADDR, VARTAB_ADDR, r_ptr_idx);
                        w_mem_rd   = 1'b1;
                        w_tmo_cnt  = '0;
                    end
                end
                ST_CHK: begin
                    if (r_end_addr < r_cur_addr) begin
                        w_state = ST_IDLE;
                        w_busy  = 1'b0;
                        w_error = 1'b1;
                    end else begin
                        w_state    = ST_HDR_LO;
                        w_up_data  = r_cur_addr[7:0];
                        w_up_valid = 1'b1;
                    end
                end
                ST_HDR_LO: begin
                    if (w_accept) begin
                        w_state   = ST_HDR_HI;
                        w_up_data = r_cur_addr[15:8];
                    end
                end
                ST_HDR_HI, ST_OUT: begin
                    if (w_accept) begin
                        if (r_cur_addr == r_end_addr) w_end_stream = 1'b1;
                        else                          w_issue_rd   = 1'b1;
                    end
                end
                ST_RD: begin
                    if (w_rd_fire) begin
                        w_mem_rd   = 1'b0;
                        w_up_data  = bus.mem_din;
                        w_up_valid = 1'b1;
                        w_cur_addr = r_cur_addr + 16'd1;
                        w_state    = ST_OUT;
`ifdef PRG_UPLOAD_CHECKSUM_EN
                        w_csum     = r_csum ^ bus.mem_din;
`endif
                    end
                end
`ifdef PRG_UPLOAD_CHECKSUM_EN
                ST_TRL: begin
                    if (w_accept) begin
                        w_up_valid = 1'b0;
                        w_state    = ST_FIN;
                        w_done     = 1'b1;
                        w_busy     = 1'b0;
                    end
                end
`endif
                default: w_state = ST_IDLE;
            endcase

            if (w_issue_rd) begin
                w_up_valid = 1'b0;
                w_state    = ST_RD;
                w_mem_addr = r_cur_addr;
                w_mem_rd   = 1'b1;
                w_tmo_cnt  = '0;
            end
            if (w_end_stream) begin
`ifdef PRG_UPLOAD_CHECKSUM_EN
                w_state    = ST_TRL;
                w_up_data  = r_csum;
`else
                w_up_valid = 1'b0;
                w_state    = ST_FIN;
                w_done     = 1'b1;
                w_busy     = 1'b0;
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together on the edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cur_addr <= '0;
            r_end_addr <= '0;
            r_ptr_idx  <= '0;
            r_tmo_cnt  <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_up_data  <= '0;
            r_up_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef PRG_UPLOAD_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_cur_addr <= w_cur_addr;
            r_end_addr <= w_end_addr;
            r_ptr_idx  <= w_ptr_idx;
            r_tmo_cnt  <= w_tmo_cnt;
            r_mem_addr <= w_mem_addr;
            r_mem_rd   <= w_mem_rd;
            r_up_data  <= w_up_data;
            r_up_valid <= w_up_valid;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
`ifdef PRG_UPLOAD_CHECKSUM_EN
            r_csum     <= w_csum;
`endif
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.up_data  = r_up_data;
    assign bus.up_valid = r_up_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_prg_upload.sv
// Directed bench for prg_upload: memory responder with 3-cycle ack latency and a stream monitor.
module tb_prg_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, auto_range = 1'b0;
    logic [15:0] start_addr = '0, end_addr = '0;
    logic        busy, done, error;

    prg_upload_if bus ();

    prg_upload dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_auto_range (auto_range),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .bus          (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [0:65535];
    int  tests_run = 0, tests_failed = 0;
    int  cyc = 0;
    bit  ack_en = 1'b1, rand_ready = 1'b0;

    // Monitor-owned history; tests read it relative to base snapshots.
    logic [7:0]  got_q [$];
    int          acc_cyc_q [$];
    logic [15:0] rd_addr_q [$];
    int          rise_cyc_q [$];
    int          done_cnt = 0, err_cnt = 0, done_cyc = 0, rd_high = 0;
    int          stall_err = 0, done_busy_err = 0;
    logic        prev_rd = 1'b0, prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    int q_base, rd_base, done_base, err_base, high_base, stall_base;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory responder and ready driver, updated just after each rising edge.
    initial begin
        int  lat_cnt;
        bit  acked;
        lat_cnt = 0;
        acked   = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_din  = '0;
        bus.up_ready = 1'b1;
        forever begin
            @(posedge clk_sys);
            #1;
            bus.mem_ack  = 1'b0;
            bus.up_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bus.mem_rd) begin
                lat_cnt = 0;
                acked   = 1'b0;
            end else if (ack_en && !acked) begin
                lat_cnt++;
                if (lat_cnt == 3) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_din = mem[bus.mem_addr];
                    acked       = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (bus.up_valid && bus.up_ready) begin
            got_q.push_back(bus.up_data);
            acc_cyc_q.push_back(cyc);
        end
        if (prev_stall && (!bus.up_valid || bus.up_data !== prev_data))
            stall_err <= stall_err + 1;
        prev_stall <= bus.up_valid && !bus.up_ready;
        prev_data  <= bus.up_data;
        if (bus.mem_rd && !prev_rd) begin
            rd_addr_q.push_back(bus.mem_addr);
            rise_cyc_q.push_back(cyc);
        end
        prev_rd <= bus.mem_rd;
        if (bus.mem_rd) rd_high <= rd_high + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (busy) done_busy_err <= done_busy_err + 1;
        end
        if (error) err_cnt <= err_cnt + 1;
    end

    task automatic snapshot();
        q_base     = got_q.size();
        rd_base    = rd_addr_q.size();
        done_base  = done_cnt;
        err_base   = err_cnt;
        high_base  = rd_high;
        stall_base = stall_err;
    endtask

    task automatic pulse_start(input logic a, input logic [15:0] sa, input logic [15:0] ea);
        @(posedge clk_sys); #1;
        snapshot();
        start = 1'b1; auto_range = a; start_addr = sa; end_addr = ea;
        @(posedge clk_sys); #1;
        start = 1'b0;
    endtask

    task automatic run_upload(input logic a, input logic [15:0] sa, input logic [15:0] ea,
                              input int budget, output bit finished);
        int n;
        pulse_start(a, sa, ea);
        n = 0;
        while (done_cnt == done_base && err_cnt == err_base && n < budget) begin
            @(posedge clk_sys); #1;
            n++;
        end
        finished = (n < budget);
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        tests_run++;
        if ({busy, done, error, bus.mem_rd, bus.up_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, error, bus.mem_rd, bus.up_valid});
        end
        tests_run++;
        if ({bus.mem_addr, bus.up_data} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_regs got=%h want=000000", {bus.mem_addr, bus.up_data});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [7:0] exp [$];
        bit fin;
        mem[16'h1001] = 8'hD0; mem[16'h1002] = 8'hD1; mem[16'h1003] = 8'hD2;
        exp = '{8'h01, 8'h10, 8'hD0, 8'hD1, 8'hD2};
`ifdef PRG_UPLOAD_CHECKSUM_EN
        exp.push_back(8'hD3);
`endif
        run_upload(1'b0, 16'h1001, 16'h1004, 200, fin);
        tests_run++;
        if (!fin) begin tests_failed++; $display("FAIL manual_timeout got=no_done want=done"); end
        tests_run++;
        if (got_q.size() - q_base != exp.size()) begin
            tests_failed++;
            $display("FAIL manual_len got=%0d want=%0d", got_q.size() - q_base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests_run++;
                if (got_q[q_base+i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL manual_byte%0d got=%h want=%h", i, got_q[q_base+i], exp[i]);
                end
            end
            tests_run++;
            if (rise_cyc_q[rd_base] - acc_cyc_q[q_base+1] != 1) begin
                tests_failed++;
                $display("FAIL manual_first_rd_lat got=%0d want=1", rise_cyc_q[rd_base] - acc_cyc_q[q_base+1]);
            end
            tests_run++;
            if (done_cyc - acc_cyc_q[q_base+exp.size()-1] != 1) begin
                tests_failed++;
                $display("FAIL manual_done_lat got=%0d want=1", done_cyc - acc_cyc_q[q_base+exp.size()-1]);
            end
        end
        tests_run++;
        if (rd_addr_q.size() - rd_base != 3 || done_cnt - done_base != 1) begin
            tests_failed++;
            $display("FAIL manual_counts reads=%0d dones=%0d want reads=3 dones=1",
                     rd_addr_q.size() - rd_base, done_cnt - done_base);
        end
        tests_run++;
        if (done_busy_err != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL manual_busy_at_done got=%0d busy=%b want=0 busy=0", done_busy_err, busy);
        end
    endtask

    task automatic test_auto();
        logic [7:0]  exp [$];
        logic [15:0] exp_rd [$];
        bit fin;
        mem[16'h002B] = 8'h01; mem[16'h002C] = 8'h12;
        mem[16'h002D] = 8'h05; mem[16'h002E] = 8'h12;
        mem[16'h1201] = 8'h11; mem[16'h1202] = 8'h22; mem[16'h1203] = 8'h33; mem[16'h1204] = 8'h44;
        exp    = '{8'h01, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_rd = '{16'h002B, 16'h002C, 16'h002D, 16'h002E, 16'h1201, 16'h1202, 16'h1203, 16'h1204};
`ifdef PRG_UPLOAD_CHECKSUM_EN
        exp.push_back(8'h44);
`endif
        run_upload(1'b1, 16'hFFFF, 16'h0000, 300, fin);
        tests_run++;
        if (!fin || done_cnt - done_base != 1) begin
            tests_failed++;
            $display("FAIL auto_done got=%0d want=1", done_cnt - done_base);
        end
        tests_run++;
        if (rd_addr_q.size() - rd_base != exp_rd.size()) begin
            tests_failed++;
            $display("FAIL auto_rd_count got=%0d want=%0d", rd_addr_q.size() - rd_base, exp_rd.size());
        end else begin
            for (int i = 0; i < exp_rd.size(); i++) begin
                tests_run++;
                if (rd_addr_q[rd_base+i] !== exp_rd[i]) begin
                    tests_failed++;
                    $display("FAIL auto_rd_addr%0d got=%h want=%h", i, rd_addr_q[rd_base+i], exp_rd[i]);
                end
            end
        end
        tests_run++;
        if (got_q.size() - q_base != exp.size()) begin
            tests_failed++;
            $display("FAIL auto_len got=%0d want=%0d", got_q.size() - q_base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests_run++;
                if (got_q[q_base+i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL auto_byte%0d got=%h want=%h", i, got_q[q_base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] exp [$];
        bit fin;
        run_upload(1'b0, 16'h2000, 16'h1000, 50, fin);
        tests_run++;
        if (!fin || err_cnt - err_base != 1 || done_cnt != done_base) begin
            tests_failed++;
            $display("FAIL range_err errors=%0d dones=%0d want errors=1 dones=0",
                     err_cnt - err_base, done_cnt - done_base);
        end
        tests_run++;
        if (got_q.size() != q_base || rd_addr_q.size() != rd_base || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_err_quiet bytes=%0d reads=%0d busy=%b want 0 0 0",
                     got_q.size() - q_base, rd_addr_q.size() - rd_base, busy);
        end
        exp = '{8'h00, 8'hA0};
`ifdef PRG_UPLOAD_CHECKSUM_EN
        exp.push_back(8'h00);
`endif
        run_upload(1'b0, 16'hA000, 16'hA000, 50, fin);
        tests_run++;
        if (!fin || done_cnt - done_base != 1 || rd_addr_q.size() != rd_base) begin
            tests_failed++;
            $display("FAIL range_empty dones=%0d reads=%0d want dones=1 reads=0",
                     done_cnt - done_base, rd_addr_q.size() - rd_base);
        end
        tests_run++;
        if (got_q.size() - q_base != exp.size()) begin
            tests_failed++;
            $display("FAIL range_empty_len got=%0d want=%0d", got_q.size() - q_base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests_run++;
                if (got_q[q_base+i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL range_empty_byte%0d got=%h want=%h", i, got_q[q_base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [$];
        bit fin;
        exp = '{8'h00, 8'h30, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) mem[16'h3000 + 16'(i)] = exp[i+2];
`ifdef PRG_UPLOAD_CHECKSUM_EN
        exp.push_back(8'hFF);
`endif
        rand_ready = 1'b1;
        run_upload(1'b0, 16'h3000, 16'h3008, 1000, fin);
        rand_ready = 1'b0;
        tests_run++;
        if (!fin || stall_err != stall_base) begin
            tests_failed++;
            $display("FAIL bp_stall_stable violations=%0d finished=%0d want 0 1", stall_err - stall_base, fin);
        end
        tests_run++;
        if (rd_addr_q.size() - rd_base != 8) begin
            tests_failed++;
            $display("FAIL bp_reads got=%0d want=8", rd_addr_q.size() - rd_base);
        end
        tests_run++;
        if (got_q.size() - q_base != exp.size()) begin
            tests_failed++;
            $display("FAIL bp_len got=%0d want=%0d", got_q.size() - q_base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests_run++;
                if (got_q[q_base+i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL bp_byte%0d got=%h want=%h", i, got_q[q_base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit fin;
        ack_en = 1'b0;
        run_upload(1'b0, 16'h4000, 16'h4002, 400, fin);
        ack_en = 1'b1;
        tests_run++;
        if (!fin || err_cnt - err_base != 1 || done_cnt != done_base) begin
            tests_failed++;
            $display("FAIL timeout_err errors=%0d dones=%0d want errors=1 dones=0",
                     err_cnt - err_base, done_cnt - done_base);
        end
        tests_run++;
        if (rd_high - high_base != 255) begin
            tests_failed++;
            $display("FAIL timeout_len got=%0d want=255", rd_high - high_base);
        end
        tests_run++;
        if (bus.mem_rd !== 1'b0 || busy !== 1'b0 || got_q.size() - q_base != 2) begin
            tests_failed++;
            $display("FAIL timeout_after mem_rd=%b busy=%b bytes=%0d want 0 0 2",
                     bus.mem_rd, busy, got_q.size() - q_base);
        end
    endtask

    task automatic test_abort();
        int n;
        for (int i = 0; i < 16; i++) mem[16'h5000 + 16'(i)] = 8'(8'hA0 + i);
        pulse_start(1'b0, 16'h5000, 16'h5010);
        n = 0;
        while (got_q.size() - q_base < 5 && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        tests_run++;
        if (n >= 200) begin tests_failed++; $display("FAIL abort_setup got=stalled want=5 bytes"); end
        abort = 1'b1;
        @(posedge clk_sys); #1;
        abort = 1'b0;
        tests_run++;
        if ({bus.up_valid, bus.mem_rd, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_next_cycle got=%b want=000", {bus.up_valid, bus.mem_rd, busy});
        end
        repeat (20) @(posedge clk_sys);
        #1;
        tests_run++;
        if (done_cnt != done_base || err_cnt != err_base || bus.up_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_quiet dones=%0d errors=%0d valid=%b want 0 0 0",
                     done_cnt - done_base, err_cnt - err_base, bus.up_valid);
        end
        // Abort coinciding with start must leave the block idle.
        snapshot();
        start = 1'b1; abort = 1'b1; start_addr = 16'h5000; end_addr = 16'h5001;
        @(posedge clk_sys); #1;
        start = 1'b0; abort = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1;
        tests_run++;
        if (busy !== 1'b0 || got_q.size() != q_base) begin
            tests_failed++;
            $display("FAIL abort_wins busy=%b bytes=%0d want 0 0", busy, got_q.size() - q_base);
        end
    endtask

    task automatic test_async_reset();
        int n;
        pulse_start(1'b0, 16'h7000, 16'h7008);
        n = 0;
        while (got_q.size() - q_base < 3 && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, bus.up_valid, bus.mem_rd, done, error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset got=%b want=00000", {busy, bus.up_valid, bus.mem_rd, done, error});
        end
        @(posedge clk_sys); #3;
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        tests_run++;
        if (busy !== 1'b0 || bus.up_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_idle busy=%b valid=%b want 0 0", busy, bus.up_valid);
        end
    endtask

    task automatic test_checksum();
        logic [7:0] exp [$];
        bit fin;
        mem[16'h6000] = 8'h12; mem[16'h6001] = 8'h34; mem[16'h6002] = 8'h56;
        exp = '{8'h00, 8'h60, 8'h12, 8'h34, 8'h56};
`ifdef PRG_UPLOAD_CHECKSUM_EN
        exp.push_back(8'h70);
`endif
        run_upload(1'b0, 16'h6000, 16'h6003, 200, fin);
        tests_run++;
        if (!fin || done_cnt - done_base != 1) begin
            tests_failed++;
            $display("FAIL csum_done got=%0d want=1", done_cnt - done_base);
        end
        tests_run++;
        if (got_q.size() - q_base != exp.size()) begin
            tests_failed++;
            $display("FAIL csum_len got=%0d want=%0d", got_q.size() - q_base, exp.size());
        end else begin
            tests_run++;
            if (got_q[q_base+exp.size()-1] !== exp[exp.size()-1]) begin
                tests_failed++;
                $display("FAIL csum_last got=%h want=%h", got_q[q_base+exp.size()-1], exp[exp.size()-1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_manual();
        test_auto();
        test_range();
        test_backpressure();
        test_timeout();
        test_abort();
        test_async_reset();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
